// File: rtl/pong_input_pkg.sv
// Purpose : shared encodings for the pong input path (owner/source codes, mode, command bit layout).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package pong_input_pkg;

    // Owner and source codes share one encoding, identical to the existing input_mode values.
    typedef enum logic [1:0] {
        OWN_BTN  = 2'd0,
        OWN_KBD  = 2'd1,
        OWN_PAD  = 2'd2,
        OWN_NONE = 2'd3
    } owner_e;

    localparam logic [1:0] MODE_AUTO = 2'd3;

    // Bit positions inside every 4-bit source command vector.
    localparam int CMD_P1_UP   = 0;
    localparam int CMD_P1_DOWN = 1;
    localparam int CMD_P2_UP   = 2;
    localparam int CMD_P2_DOWN = 3;

    // Bit positions inside src_present.
    localparam int SRC_BTN = 0;
    localparam int SRC_KBD = 1;
    localparam int SRC_PAD = 2;

    // Up and down together means the player is confused; drive neither.
    function automatic logic [1:0] cancel_conflict(input logic [1:0] c);
        return (&c) ? 2'b00 : c;
    endfunction

endpackage

// File: rtl/paddle_owner_fsm.sv
// Purpose : per-player ownership FSM choosing which source drives this paddle, with idle timeout.
// Latency : 1 cycle from input change to registered owner/cmd, including the claim edge.
// Backpressure: none; sources are level signals sampled every cycle.
//
// Ports: clk/rst (async active-low); cmd_btn/cmd_kbd/cmd_pad = masked {down,up} per source;
//        src_present = link-alive per source; mode_sel = forced source or auto;
//        owner = registered owner code; cmd = registered {down,up} after conflict cancel.
module paddle_owner_fsm
    import pong_input_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd_btn,
    input  logic [1:0] cmd_kbd,
    input  logic [1:0] cmd_pad,
    input  logic [2:0] src_present,
    input  logic [1:0] mode_sel,
    output logic [1:0] owner,
    output logic [1:0] cmd
);

    localparam int                CNT_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

    owner_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             forced_q;   // previous edge was in a forced mode
    logic [1:0]       cmd_q, cmd_d;
    logic [1:0]       owner_cmd;
    logic             owner_present;
    logic [1:0]       sel_cmd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= OWN_NONE;
            cnt_q    <= '0;
            forced_q <= 1'b0;
            cmd_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            forced_q <= (mode_sel != MODE_AUTO);
            cmd_q    <= cmd_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        owner_cmd     = 2'b00;
        owner_present = 1'b0;
        sel_cmd       = 2'b00;

        case (state_q)
            OWN_BTN: begin owner_cmd = cmd_btn; owner_present = src_present[SRC_BTN]; end
            OWN_KBD: begin owner_cmd = cmd_kbd; owner_present = src_present[SRC_KBD]; end
            OWN_PAD: begin owner_cmd = cmd_pad; owner_present = src_present[SRC_PAD]; end
            default: begin owner_cmd = 2'b00;   owner_present = 1'b0;                 end
        endcase

        if (mode_sel != MODE_AUTO) begin
            state_d = owner_e'(mode_sel);
        end else if (forced_q) begin
            // Leaving a forced mode always starts auto arbitration from scratch.
            state_d = OWN_NONE;
        end else if (state_q == OWN_NONE) begin
            if      (|cmd_pad) state_d = OWN_PAD;
            else if (|cmd_kbd) state_d = OWN_KBD;
            else if (|cmd_btn) state_d = OWN_BTN;
        end else if (!owner_present) begin
            state_d = OWN_NONE;
        end else if (|owner_cmd) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // A release edge never re-claims; any waiting source gets it next edge.
            state_d = OWN_NONE;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Outputs come from the owner chosen on this same edge.
        case (state_d)
            OWN_BTN: sel_cmd = cmd_btn;
            OWN_KBD: sel_cmd = cmd_kbd;
            OWN_PAD: sel_cmd = cmd_pad;
            default: sel_cmd = 2'b00;
        endcase
        cmd_d = cancel_conflict(sel_cmd);
    end

    assign owner = state_q;
    assign cmd   = cmd_q;

endmodule

// File: rtl/paddle_input_arbiter.sv
// Purpose : masks absent input sources and arbitrates per-player paddle ownership between btn/kbd/pad.
// Latency : 1 cycle from source input to registered paddle command and owner.
// Backpressure: none; all inputs are levels sampled every cycle.
//
// Ports: clk/rst (async active-low); mode_sel 0..2 forces a source, 3 = auto;
//        src_btn/src_kbd/src_pad = {p2_down,p2_up,p1_down,p1_up}; src_present = link alive per source;
//        p1_up..p2_down = registered commands; p1_owner/p2_owner = 0 btn, 1 kbd, 2 pad, 3 none.
module paddle_input_arbiter
    import pong_input_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode_sel,
    input  logic [3:0] src_btn,
    input  logic [3:0] src_kbd,
    input  logic [3:0] src_pad,
    input  logic [2:0] src_present,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic [1:0] p1_owner,
    output logic [1:0] p2_owner
);

    logic [3:0] btn_m, kbd_m, pad_m;
    logic [1:0] p1_cmd, p2_cmd;

    // An absent source looks completely idle to everything downstream.
    assign btn_m = src_btn & {4{src_present[SRC_BTN]}};
    assign kbd_m = src_kbd & {4{src_present[SRC_KBD]}};
    assign pad_m = src_pad & {4{src_present[SRC_PAD]}};

    paddle_owner_fsm #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_p1 (
        .clk         (clk),
        .rst         (rst),
        .cmd_btn     (btn_m[CMD_P1_DOWN:CMD_P1_UP]),
        .cmd_kbd     (kbd_m[CMD_P1_DOWN:CMD_P1_UP]),
        .cmd_pad     (pad_m[CMD_P1_DOWN:CMD_P1_UP]),
        .src_present (src_present),
        .mode_sel    (mode_sel),
        .owner       (p1_owner),
        .cmd         (p1_cmd)
    );

    paddle_owner_fsm #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_p2 (
        .clk         (clk),
        .rst         (rst),
        .cmd_btn     (btn_m[CMD_P2_DOWN:CMD_P2_UP]),
        .cmd_kbd     (kbd_m[CMD_P2_DOWN:CMD_P2_UP]),
        .cmd_pad     (pad_m[CMD_P2_DOWN:CMD_P2_UP]),
        .src_present (src_present),
        .mode_sel    (mode_sel),
        .owner       (p2_owner),
        .cmd         (p2_cmd)
    );

    assign p1_up   = p1_cmd[0];
    assign p1_down = p1_cmd[1];
    assign p2_up   = p2_cmd[0];
    assign p2_down = p2_cmd[1];

endmodule

// File: doc/paddle_input_arbiter.md
Name: paddle_input_arbiter

Overview:
- Sits between the debounced/decoded input sources (pushbuttons, UART keyboard, PS4 pad) and the paddle logic.
- Decides, per player, which source currently owns that paddle, and drives the four paddle commands from the owner.
- Ownership is taken on first activity, held while the owner stays active, and released after an inactivity timeout.
- A manual mode select can force one source for both players.

Parameters:
- IDLE_TIMEOUT, 50_000_000: consecutive owner-inactive cycles before release (1 s at 50 MHz); legal range ≥2.
- CNT_W, $clog2(IDLE_TIMEOUT+1): inactivity counter width (derived; not overridden).

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  Reset, asynchronous, active-low
- mode_sel  in  2  0=force buttons, 1=force keyboard, 2=force pad, 3=auto arbitration
- src_btn  in  4  {p2_down,p2_up,p1_down,p1_up}, active-high, already debounced/inverted
- src_kbd  in  4  same bit order, keyboard decoder
- src_pad  in  4  same bit order, controller decoder
- src_present  in  3  [0]=btn, [1]=kbd, [2]=pad link alive; btn tied 1 at top level
- p1_up, p1_down, p2_up, p2_down  out  1 each  registered paddle commands
- p1_owner, p2_owner  out  2 each  current owner: 0=btn, 1=kbd, 2=pad, 3=none

Behaviour:
- Reset (rst=0, async): all paddle outputs 0, both owners 3 (none), counters 0. First evaluation happens on the first clk edge after deassertion.
- Masking: a source with src_present=0 has its 4 bits treated as 0 everywhere.
- Activity: player N's activity on source S = OR of that player's two masked bits from S.
- Per-player FSM states: NONE, OWN_BTN, OWN_KBD, OWN_PAD.
- Auto mode (mode_sel=3):
  - NONE: if any source is active for that player, claim it on this edge. Simultaneous claim priority: pad > kbd > btn. Otherwise stay NONE.
  - OWN_x, owner active: counter cleared to 0. Activity from non-owners is ignored (no stealing).
  - OWN_x, owner inactive: counter increments. On the edge where counter==IDLE_TIMEOUT-1 (the IDLE_TIMEOUT-th consecutive inactive cycle), go to NONE and clear the counter.
  - OWN_x, owner's src_present falls: go to NONE on the next edge, regardless of the counter.
  - Release edge with other sources active: go to NONE only. A re-claim occurs on a later edge if activity persists (one-cycle gap).
- Forced mode (mode_sel 0..2):
  - Both owners = mode_sel on the next edge; counters held at 0.
  - Outputs follow the masked forced source, so they are 0 if that source is not present.
- mode_sel change:
  - Takes effect on the next edge.
  - Forced→auto: both owners go to NONE and counters clear.
  - Auto→forced: immediate override, no timeout.
- Output datapath: on each edge, outputs = masked bits of the owner selected on that same edge, from inputs sampled at that edge.
  - Latency: one cycle from input change to output, including the claim edge.
  - Owner NONE → outputs 0.
- Conflict: owner asserts up and down for one player together → both outputs for that player 0 that cycle. Ownership/counter still count this as activity.
- Players are fully independent: different owners allowed, e.g. P1 on kbd and P2 on pad.

Decomposition:
- Shared package (pong_input_pkg):
  - owner/source encodings OWN_BTN=0, OWN_KBD=1, OWN_PAD=2, OWN_NONE=3 (identical to the existing input_mode encoding)
  - MODE_AUTO=3
  - bit-index constants for the 4-bit command vector
- Sub-module paddle_owner_fsm, instantiated twice (one per player):
  - inputs: three 2-bit masked commands, presence, mode_sel
  - outputs: owner code and 2-bit up/down
  - contains the FSM, counter and conflict cancel
- Top handles masking and output packing only.

Test Plan (IDLE_TIMEOUT=8):
- Reset: hold rst=0 with src_btn=4'b1111 → all outputs 0, owners 3. Release rst, src_kbd=4'b0001 → one edge later p1_owner=1, p1_up=1, p2_owner=3.
- Priority: from NONE, same cycle src_btn=4'b0001, src_pad=4'b0010 → p1_owner=2, p1_down=1, p1_up=0. Then btn held alone → p1_up stays 0 (no steal).
- Timeout: kbd owns P1; drive src_kbd=0 → owner stays 1 for 7 edges, becomes 3 on the 8th. A kbd pulse at inactive cycle 5 restarts the count.
- Link loss: pad owns P2; src_present[2]→0 while src_pad=4'b0100 → next edge p2_owner=3 and p2_up=0. btn active → claim on the following edge.
- Forced mode: mode_sel=0 with src_pad=4'b1111, src_btn=4'b0100 → both owners 0, p2_up=1, others 0. Switch to mode_sel=3 → owners 3 next edge.
- Conflict: owner source drives 4'b0011 → p1_up=p1_down=0, counter stays 0, and ownership is held past 8 cycles.
